obstacle_scheduler: RTL

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

---
 rtl/obstacle_scheduler.sv | 93 +++++++++
 1 files changed

// File: rtl/obstacle_scheduler.sv
// Cactus spawn sequencer for the runner game: tracks IDLE/RUN/CRASH, counts
// survived frames and issues one-frame spawn requests at pseudo-random gaps.
//
// state    | meaning
// ST_IDLE  | power-up, waiting for the first start request
// ST_RUN   | game active: score counts, gap timer runs, spawns issued
// ST_CRASH | dino hit an obstacle, everything frozen until restart
module obstacle_scheduler #(
   parameter int NUM_SLOTS = 3,
   parameter int MIN_GAP   = 40
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 next_frame_i,
   input  logic                 start_i,
   input  logic                 collision_i,
   input  logic [NUM_SLOTS-1:0] slot_free_i,
   output logic [NUM_SLOTS-1:0] spawn_o,
   output logic [1:0]           rand_o,
   output logic                 running_o,
   output logic                 crashed_o,
   output logic                 restart_o,
   output logic [15:0]          score_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CRASH = 2'd2
   } state_t;

   localparam logic [7:0] GAP_INIT = 8'(MIN_GAP);

   state_t               state_q;
   logic [7:0]           lfsr_q;
   logic [7:0]           gap_q;
   logic                 lfsr_fb;
   logic [7:0]           gap_reload;
   logic [NUM_SLOTS-1:0] first_free;

   // x^8+x^6+x^5+x^4+1 maps to bits 7,5,4,3 of the left-shifting register
   assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
   assign gap_reload = GAP_INIT + {3'b000, lfsr_q[6:2]};
   assign first_free = slot_free_i & (~slot_free_i + NUM_SLOTS'(1));

   assign running_o = (state_q == ST_RUN);
   assign crashed_o = (state_q == ST_CRASH);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         lfsr_q    <= 8'hA5;
         gap_q     <= GAP_INIT;
         spawn_o   <= '0;
         rand_o    <= 2'd0;
         restart_o <= 1'b0;
         score_o   <= 16'd0;
      end else begin
         lfsr_q    <= {lfsr_q[6:0], lfsr_fb};
         restart_o <= 1'b0;
         case (state_q)
            ST_IDLE, ST_CRASH: begin
               if (start_i) begin
                  state_q   <= ST_RUN;
                  restart_o <= 1'b1;
                  gap_q     <= GAP_INIT;
                  score_o   <= 16'd0;
                  spawn_o   <= '0;
               end
            end
            ST_RUN: begin
               if (collision_i) begin
                  state_q <= ST_CRASH;
                  spawn_o <= '0;
               end else if (next_frame_i) begin
                  if (score_o != 16'hFFFF) score_o <= score_o + 16'd1;
                  // a request lives for exactly one frame interval
                  if (spawn_o != '0) spawn_o <= '0;
                  if (gap_q != 8'd0) begin
                     gap_q <= gap_q - 8'd1;
                  end else if (spawn_o == '0 && slot_free_i != '0) begin
                     spawn_o <= first_free;
                     rand_o  <= lfsr_q[1:0];
                     gap_q   <= gap_reload;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
